cshm_coef_loader: RTL and testbench

Coefficient writer for the 4-tap CSHM FIR filter. Accepts a serial stream of 9-bit coefficient words over a valid/ready handshake, assembles them in a shadow bank, and commits all four to the filter's c0..c3 inputs atomically on a sample boundary, so the filter never sees a mixed coefficient set. It sits between the host/config path and the filter's coefficient ports.

---
 rtl/cshm_pkg.sv | 24 ++
 rtl/cshm_coef_bank.sv | 51 +++++
 rtl/cshm_coef_loader.sv | 168 ++++++++++++++++
 tb/tb_cshm_coef_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cshm_pkg.sv
// Shared definitions for the CSHM coefficient loader: word/tap sizes, loader
// state encoding, word-index type and the parity helper.
package cshm_pkg;

   localparam int unsigned CW   = 9;
   localparam int unsigned NTAP = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StPend  = 2'd2,
      StDrain = 2'd3
   } state_e;

   typedef logic [1:0] idx_t;

   localparam idx_t LastIdx = idx_t'(NTAP - 1);

   // Even parity over {par, data}: total number of ones must be even.
   function automatic logic par_ok(input logic par, input logic [CW-1:0] data);
      return ~(^{par, data});
   endfunction

endpackage

// File: rtl/cshm_coef_bank.sv
// Shadow and active coefficient registers. The shadow bank takes indexed
// writes while a frame is assembled; the active bank loads the whole shadow
// bank in one edge so the filter never sees a partial update.
module cshm_coef_bank
   import cshm_pkg::*;
#(
   parameter int unsigned CW   = cshm_pkg::CW,
   parameter int unsigned NTAP = cshm_pkg::NTAP
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  idx_t                     wr_idx_i,
   input  logic [CW-1:0]            wr_data_i,
   input  logic                     load_i,
   output logic [NTAP-1:0][CW-1:0]  active_o
);

   logic [NTAP-1:0][CW-1:0] shadow_q, shadow_d;
   logic [NTAP-1:0][CW-1:0] active_q, active_d;

   // Indexed write into the shadow bank.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en_i) begin
         shadow_d[wr_idx_i] = wr_data_i;
      end
   end

   // Active set changes only on an explicit commit load.
   always_comb begin
      active_d = active_q;
      if (load_i) begin
         active_d = shadow_q;
      end
   end

   // Bank state, synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign active_o = active_q;

endmodule

// File: rtl/cshm_coef_loader.sv
// Coefficient loader for the 4-tap CSHM FIR. Collects a framed stream of
// coefficient words into a shadow bank and commits all taps at once on the
// next sample strobe. Malformed frames pulse err and leave the active set
// untouched.
// Optional feature: define CSHM_COEF_PARITY_EN to add the s_par input and an
// even-parity check over {s_par, s_data} on every accepted word.
// Note: resetn is active-high despite its name (asserted = 1).
module cshm_coef_loader
   import cshm_pkg::*;
#(
   parameter int unsigned CW   = cshm_pkg::CW,
   parameter int unsigned NTAP = cshm_pkg::NTAP
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [CW-1:0] s_data,
   input  logic          s_last,
`ifdef CSHM_COEF_PARITY_EN
   input  logic          s_par,
`endif
   input  logic          sample_strobe,
   output logic [CW-1:0] c0,
   output logic [CW-1:0] c1,
   output logic [CW-1:0] c2,
   output logic [CW-1:0] c3,
   output logic          busy,
   output logic          commit,
   output logic          err
);

   state_e state_q, state_d;
   idx_t   idx_q, idx_d;
   logic   commit_q, commit_d;
   logic   err_q, err_d;

   logic   accept;
   logic   par_bad;
   logic   wr_en;
   idx_t   wr_idx;
   logic   load;

   logic [NTAP-1:0][CW-1:0] active;

   // Ready is a pure decode of the registered state, held low during reset.
   assign s_ready = (state_q != StPend) & ~resetn;
   assign accept  = s_valid & s_ready;
   assign busy    = (state_q != StIdle);

`ifdef CSHM_COEF_PARITY_EN
   assign par_bad = ~par_ok(s_par, s_data);
`else
   assign par_bad = 1'b0;
`endif

   // Next-state, shadow write and commit decisions.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      commit_d = 1'b0;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = idx_q;
      load     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (par_bad) begin
                  err_d   = 1'b1;
                  state_d = s_last ? StIdle : StDrain;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = '0;
                  if (s_last) begin
                     // Single-word frame is too short.
                     err_d = 1'b1;
                  end else begin
                     idx_d   = idx_t'(1);
                     state_d = StLoad;
                  end
               end
            end
         end
         StLoad: begin
            if (accept) begin
               if (par_bad) begin
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = s_last ? StIdle : StDrain;
               end else begin
                  wr_en = 1'b1;
                  if (idx_q == LastIdx) begin
                     idx_d = '0;
                     if (s_last) begin
                        state_d = StPend;
                     end else begin
                        // Long frame: reject now, swallow the rest.
                        err_d   = 1'b1;
                        state_d = StDrain;
                     end
                  end else if (s_last) begin
                     err_d   = 1'b1;
                     idx_d   = '0;
                     state_d = StIdle;
                  end else begin
                     idx_d = idx_t'(idx_q + idx_t'(1));
                  end
               end
            end
         end
         StPend: begin
            if (sample_strobe) begin
               load     = 1'b1;
               commit_d = 1'b1;
               state_d  = StIdle;
            end
         end
         StDrain: begin
            if (accept && s_last) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   // FSM state and registered status pulses.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         commit_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         commit_q <= commit_d;
         err_q    <= err_d;
      end
   end

   assign commit = commit_q;
   assign err    = err_q;

   cshm_coef_bank #(
      .CW   (CW),
      .NTAP (NTAP)
   ) u_bank (
      .clk_i     (clk),
      .rst_i     (resetn),
      .wr_en_i   (wr_en),
      .wr_idx_i  (wr_idx),
      .wr_data_i (s_data),
      .load_i    (load),
      .active_o  (active)
   );

   assign c0 = active[0];
   assign c1 = active[1];
   assign c2 = active[2];
   assign c3 = active[3];

endmodule

// File: tb/tb_cshm_coef_loader.sv
// Self-checking bench for cshm_coef_loader: directed frames with literal
// expectations, then randomized traffic checked every cycle against a
// frame-level model (word count, drain/pending flags, active set array).
module tb_cshm_coef_loader;

`ifdef CSHM_COEF_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn;
   logic       s_valid;
   logic       s_ready;
   logic [8:0] s_data;
   logic       s_last;
   logic       s_par;
   logic       sample_strobe;
   logic [8:0] c0, c1, c2, c3;
   logic       busy, commit, err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cshm_coef_loader dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_last        (s_last),
`ifdef CSHM_COEF_PARITY_EN
      .s_par         (s_par),
`endif
      .sample_strobe (sample_strobe),
      .c0            (c0),
      .c1            (c1),
      .c2            (c2),
      .c3            (c3),
      .busy          (busy),
      .commit        (commit),
      .err           (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic [8:0] m_active [4];
   logic [8:0] m_frame  [4];
   int         m_n     = 0;   // words collected in current frame
   bit         m_drain = 0;
   bit         m_pend  = 0;
   bit         m_commit = 0;
   bit         m_err    = 0;
   bit         m_live   = 0;

   // Advance the model on each rising edge from the inputs of that cycle.
   always @(posedge clk) begin
      bit acc;
      bit bad;
      m_commit = 0;
      m_err    = 0;
      if (resetn) begin
         m_n = 0; m_drain = 0; m_pend = 0; m_live = 1;
         for (int i = 0; i < 4; i++) begin
            m_active[i] = '0;
            m_frame[i]  = '0;
         end
      end else if (m_live) begin
         acc = s_valid && !m_pend;
         if (m_pend) begin
            if (sample_strobe) begin
               m_active = m_frame;
               m_commit = 1; m_pend = 0; m_n = 0;
            end
         end else if (acc) begin
            if (m_drain) begin
               if (s_last) m_drain = 0;
            end else begin
               bad = ParEn && (^{s_par, s_data});
               if (bad) begin
                  m_err = 1; m_n = 0; m_drain = !s_last;
               end else begin
                  m_frame[m_n] = s_data;
                  m_n++;
                  if (s_last) begin
                     if (m_n == 4) m_pend = 1;
                     else begin m_err = 1; m_n = 0; end
                  end else if (m_n == 4) begin
                     m_err = 1; m_drain = 1; m_n = 0;
                  end
               end
            end
         end
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("s_ready", 32'(s_ready), 32'(!resetn && !m_pend));
         chk("busy",    32'(busy),    32'((m_n > 0) || m_drain || m_pend));
         chk("commit",  32'(commit),  32'(m_commit));
         chk("err",     32'(err),     32'(m_err));
         chk("c0",      32'(c0),      32'(m_active[0]));
         chk("c1",      32'(c1),      32'(m_active[1]));
         chk("c2",      32'(c2),      32'(m_active[2]));
         chk("c3",      32'(c3),      32'(m_active[3]));
      end
   end

   // One cycle of stimulus; returns 1 time unit after the rising edge.
   task automatic cyc(input logic rst, input logic v, input logic [8:0] d, input logic last,
                      input logic stb, input logic badpar);
      resetn        = rst;
      s_valid       = v;
      s_data        = d;
      s_last        = last;
      sample_strobe = stb;
      s_par         = (^d) ^ badpar;
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [8:0] d, input logic last);
      cyc(1'b0, 1'b1, d, last, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset
      cyc(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 9'h1AA, 1'b0, 1'b0, 1'b0);
      chk("rst_c0", 32'(c0), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(s_ready), 32'h0);
      resetn = 1'b0; s_valid = 1'b0;
      #1;
      chk("ready_after_rst", 32'(s_ready), 32'h1);

      // Basic frame, strobe three cycles after the last word
      word(9'h102, 1'b0); word(9'h101, 1'b0); word(9'h003, 1'b0); word(9'h004, 1'b1);
      chk("pend_busy", 32'(busy), 32'h1);
      idle(2);
      cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
      chk("lit_commit", 32'(commit), 32'h1);
      chk("lit_c0", 32'(c0), 32'h102);
      chk("lit_c1", 32'(c1), 32'h101);
      chk("lit_c2", 32'(c2), 32'h003);
      chk("lit_c3", 32'(c3), 32'h004);
      chk("lit_err0", 32'(err), 32'h0);
      idle(1);
      chk("commit_pulse_1cyc", 32'(commit), 32'h0);

      // Short frame
      word(9'h055, 1'b0); word(9'h066, 1'b1);
      chk("short_err", 32'(err), 32'h1);
      chk("short_c0", 32'(c0), 32'h102);
      chk("short_idle", 32'(busy), 32'h0);
      chk("short_ready", 32'(s_ready), 32'h1);

      // Long frame of six words
      word(9'h1A0, 1'b0); word(9'h1A1, 1'b0); word(9'h1A2, 1'b0); word(9'h1A3, 1'b0);
      chk("long_err", 32'(err), 32'h1);
      chk("long_drain_busy", 32'(busy), 32'h1);
      word(9'h1A4, 1'b0);
      chk("long_err_once", 32'(err), 32'h0);
      word(9'h1A5, 1'b1);
      chk("long_done", 32'(busy), 32'h0);
      chk("long_c3", 32'(c3), 32'h004);

      // PEND hold with s_valid stuck high
      word(9'h011, 1'b0); word(9'h022, 1'b0); word(9'h033, 1'b0); word(9'h044, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
      chk("hold_ready", 32'(s_ready), 32'h0);
      chk("hold_busy", 32'(busy), 32'h1);
      chk("hold_c0", 32'(c0), 32'h102);
      cyc(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0);
      chk("hold_commit", 32'(commit), 32'h1);
      chk("hold_c2", 32'(c2), 32'h033);
      chk("hold_ready_back", 32'(s_ready), 32'h1);
      idle(1);

      // Reset mid-load
      word(9'h0F1, 1'b0); word(9'h0F2, 1'b0); word(9'h0F3, 1'b0);
      cyc(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      chk("midrst_c0", 32'(c0), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      // Strobe coinciding with the last word must not commit
      word(9'h0A1, 1'b0); word(9'h0A2, 1'b0); word(9'h0A3, 1'b0);
      cyc(1'b0, 1'b1, 9'h0A4, 1'b1, 1'b1, 1'b0);
      chk("early_strobe_nocommit", 32'(commit), 32'h0);
      chk("early_strobe_c0", 32'(c0), 32'h0);
      cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
      chk("after_rst_commit", 32'(commit), 32'h1);
      chk("after_rst_c3", 32'(c3), 32'h0A4);
      // Back-to-back: first word of next frame accepted right after commit
      chk("b2b_ready", 32'(s_ready), 32'h1);

`ifdef CSHM_COEF_PARITY_EN
      word(9'h0B1, 1'b0);
      cyc(1'b0, 1'b1, 9'h0B2, 1'b0, 1'b0, 1'b1);
      chk("par_err", 32'(err), 32'h1);
      word(9'h0B3, 1'b0); word(9'h0B4, 1'b1);
      chk("par_drained", 32'(busy), 32'h0);
      chk("par_keep_c0", 32'(c0), 32'h0A1);
      word(9'h0C1, 1'b0); word(9'h0C2, 1'b0); word(9'h0C3, 1'b0); word(9'h0C4, 1'b1);
      cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
      chk("par_commit_c1", 32'(c1), 32'h0C2);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic       r, v, l, st, bp;
         logic [8:0] d;
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 3) != 0);
         d  = 9'($urandom);
         l  = (m_n == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 2) == 0);
         bp = ($urandom_range(0, 15) == 0);
         cyc(r, v, d, l, st, bp);
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
